// File: rtl/mac_tx_sched_pkg.sv
// Shared types and constants for the MAC transmit scheduler.
package mac_tx_sched_pkg;
  localparam int MAC_ADDR_W = 48;
  localparam int ETH_TYPE_W = 16;
  localparam int LEN_W      = 16;

  localparam logic [7:0] START_CODE_DEF = 8'hFB;
  localparam logic [7:0] TERM_CODE_DEF  = 8'hFD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_TERM,
    ST_GAP
  } state_e;
endpackage

// File: rtl/mac_tx_scheduler_rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);
  localparam int IDX_W = $clog2(NUM_REQ);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = int'(i_ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (i_req[pos_idx]) begin
        o_idx   = pos_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_tx_scheduler.sv
// Shares one MAC/MII frame generator between NUM_REQ requesters: round-robin
// grant, descriptor latch, start/terminate detection, watchdog and inter-frame gap.
module mac_tx_scheduler
  import mac_tx_sched_pkg::*;
#(
  parameter int         NUM_REQ          = 4,
  parameter int         PAYLOAD_MAX_SIZE = 64,
  parameter int         IFG_CYCLES       = 3,
  parameter int         TIMEOUT_CYCLES   = 512,
  parameter logic [7:0] START_CODE       = START_CODE_DEF,
  parameter logic [7:0] TERM_CODE        = TERM_CODE_DEF
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*MAC_ADDR_W-1:0] i_dest_address,
  input  logic [NUM_REQ*ETH_TYPE_W-1:0] i_eth_type,
  input  logic [NUM_REQ*LEN_W-1:0]      i_payload_length,
  input  logic [MAC_ADDR_W-1:0]         i_src_address,
  input  logic [63:0]                   i_mii_data,
  input  logic [7:0]                    i_mii_ctrl,
  output logic                          o_start,
  output logic [MAC_ADDR_W-1:0]         o_dest_address,
  output logic [MAC_ADDR_W-1:0]         o_src_address,
  output logic [ETH_TYPE_W-1:0]         o_eth_type,
  output logic [LEN_W-1:0]              o_payload_length,
  output logic [$clog2(NUM_REQ)-1:0]    o_sel,
  output logic                          o_busy,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_err,
  output logic [15:0]                   o_frame_count
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  // Requester handshake: i_req[k] is a level held until the one-cycle o_ack[k]
  // or o_err[k] pulse; requests are sampled only while the scheduler is IDLE.
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d, ptr_q, ptr_d, sel_q, sel_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    start_q, start_d, busy_q, busy_d;
  logic [MAC_ADDR_W-1:0]   dest_q, dest_d, src_q, src_d;
  logic [ETH_TYPE_W-1:0]   type_q, type_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d, err_q, err_d;
  logic [15:0]             fcnt_q, fcnt_d;

  logic [IDX_W-1:0]        arb_idx, ptr_next;
  logic                    arb_valid, start_det, term_det, timeout, len_bad;
  logic [LEN_W-1:0]        req_len;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_idx   (arb_idx),
    .o_valid (arb_valid)
  );

  assign start_det = i_mii_ctrl[0] && (i_mii_data[7:0] == START_CODE);
  assign timeout   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign ptr_next  = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign req_len   = i_payload_length[gnt_q*LEN_W +: LEN_W];
  assign len_bad   = (req_len == '0) || (req_len > LEN_W'(PAYLOAD_MAX_SIZE));

  always_comb begin
    term_det = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (i_mii_ctrl[k] && (i_mii_data[8*k +: 8] == TERM_CODE)) term_det = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    start_d = start_q;
    dest_d  = dest_q;
    src_d   = src_q;
    type_d  = type_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dest_d = i_dest_address[gnt_q*MAC_ADDR_W +: MAC_ADDR_W];
        type_d = i_eth_type[gnt_q*ETH_TYPE_W +: ETH_TYPE_W];
        len_d  = req_len;
        src_d  = i_src_address;
        sel_d  = gnt_q;
        if (len_bad) begin
          err_d[gnt_q] = 1'b1;
          ptr_d        = ptr_next;
          gap_d        = '0;
          state_d      = ST_GAP;
        end else begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START, ST_WAIT_TERM: begin
        tmo_d = tmo_q + 1'b1;
        // Terminate outranks the watchdog; in START it only counts alongside start.
        if (term_det && (state_q == ST_WAIT_TERM || start_det)) begin
          start_d      = 1'b0;
          ack_d[gnt_q] = 1'b1;
          fcnt_d       = fcnt_q + 16'd1;
          ptr_d        = ptr_next;
          gap_d        = '0;
          state_d      = ST_GAP;
        end else if (timeout) begin
          start_d      = 1'b0;
          err_d[gnt_q] = 1'b1;
          ptr_d        = ptr_next;
          gap_d        = '0;
          state_d      = ST_GAP;
        end else if (state_q == ST_START && start_det) begin
          start_d = 1'b0;
          state_d = ST_WAIT_TERM;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(IFG_CYCLES - 1)) state_d = ST_IDLE;
        else                                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      dest_q  <= '0;
      src_q   <= '0;
      type_q  <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      type_q  <= type_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_start          = start_q;
  assign o_busy           = busy_q;
  assign o_sel            = sel_q;
  assign o_dest_address   = dest_q;
  assign o_src_address    = src_q;
  assign o_eth_type       = type_q;
  assign o_payload_length = len_q;
  assign o_ack            = ack_q;
  assign o_err            = err_q;
  assign o_frame_count    = fcnt_q;
endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Scoreboard bench for mac_tx_scheduler with a behavioural MII generator model.
module tb_mac_tx_scheduler;
  import mac_tx_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int PMAX    = 64;
  localparam int IFG     = 3;
  localparam int TMO     = 512;
  localparam int NEVER   = 100000;

  logic                  clk = 1'b0;
  logic                  i_rst_n;
  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ*48-1:0] i_dest_address;
  logic [NUM_REQ*16-1:0] i_eth_type;
  logic [NUM_REQ*16-1:0] i_payload_length;
  logic [47:0]           i_src_address;
  logic [63:0]           i_mii_data;
  logic [7:0]            i_mii_ctrl;
  logic                  o_start, o_busy;
  logic [47:0]           o_dest_address, o_src_address;
  logic [15:0]           o_eth_type, o_payload_length, o_frame_count;
  logic [1:0]            o_sel;
  logic [NUM_REQ-1:0]    o_ack, o_err;

  mac_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .PAYLOAD_MAX_SIZE(PMAX), .IFG_CYCLES(IFG),
    .TIMEOUT_CYCLES(TMO), .START_CODE(8'hFB), .TERM_CODE(8'hFD)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_dest_address(i_dest_address), .i_eth_type(i_eth_type),
    .i_payload_length(i_payload_length), .i_src_address(i_src_address),
    .i_mii_data(i_mii_data), .i_mii_ctrl(i_mii_ctrl),
    .o_start(o_start), .o_dest_address(o_dest_address),
    .o_src_address(o_src_address), .o_eth_type(o_eth_type),
    .o_payload_length(o_payload_length), .o_sel(o_sel), .o_busy(o_busy),
    .o_ack(o_ack), .o_err(o_err), .o_frame_count(o_frame_count)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_ack;
    bit          badlen;
    int          idx;
    logic [47:0] dest;
    logic [15:0] typ;
    logic [15:0] len;
    logic [47:0] src;
    logic [15:0] fc;
    int          sd;
    int          td;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   gen_sd[NUM_REQ];
  int   gen_td[NUM_REQ];
  int   m_ptr     = 0;
  logic [15:0] m_fc = 16'd0;
  int   batch_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_desc(input int k, input logic [47:0] d, input logic [15:0] t,
                          input logic [15:0] l, input int sd, input int td);
    i_dest_address[k*48 +: 48]   = d;
    i_eth_type[k*16 +: 16]       = t;
    i_payload_length[k*16 +: 16] = l;
    gen_sd[k] = sd;
    gen_td[k] = td;
  endtask

  // Reference model: requesters are served in circular order from the pointer;
  // a frame acks when its length is legal and terminate arrives before the watchdog.
  task automatic issue(input logic [NUM_REQ-1:0] mask);
    exp_t e;
    for (int off = 0; off < NUM_REQ; off++) begin
      int k;
      k = (m_ptr + off) % NUM_REQ;
      if (mask[k]) begin
        e.idx    = k;
        e.dest   = i_dest_address[k*48 +: 48];
        e.typ    = i_eth_type[k*16 +: 16];
        e.len    = i_payload_length[k*16 +: 16];
        e.src    = i_src_address;
        e.sd     = gen_sd[k];
        e.td     = gen_td[k];
        e.badlen = (e.len == 16'd0) || (e.len > 16'(PMAX));
        e.is_ack = !e.badlen && (e.td <= TMO - 1);
        if (e.is_ack) m_fc = m_fc + 16'd1;
        e.fc = m_fc;
        exp_q.push_back(e);
      end
    end
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (mask[(m_ptr + off) % NUM_REQ]) begin
        m_ptr = ((m_ptr + off) % NUM_REQ + 1) % NUM_REQ;
        break;
      end
    end
    batch_cyc = cyc;
    i_req = mask;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      i_req = i_req & ~(o_ack | o_err);
      n++;
      if (exp_q.size() == 0 && !o_busy && i_req == '0) break;
      if (n >= budget) begin
        n_checks++;
        $display("FAIL wait_done: %0d-cycle budget expired with %0d events outstanding", budget, exp_q.size());
        exp_q.delete();
        i_req = '0;
        break;
      end
    end
  endtask

  // ---------------- generator model ----------------
  initial begin
    bit act;
    int c0g, sd, td, lane, k;
    logic [63:0] data;
    logic [7:0]  ctrl;
    act = 0; c0g = 0; sd = 0; td = 0; lane = 0;
    forever begin
      @(negedge clk);
      if (!i_rst_n) act = 0;
      else if (act && (o_ack | o_err) != '0) act = 0;
      else if (!act && o_start) begin
        act  = 1;
        c0g  = cyc;
        sd   = gen_sd[o_sel];
        td   = gen_td[o_sel];
        lane = (sd == td) ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 7));
      end
      data = 64'h0707070707070707;
      ctrl = 8'hFF;
      if (act) begin
        k = cyc - c0g;
        if (k > sd && k < td) begin
          data = {$urandom, $urandom};
          ctrl = 8'h00;
        end
        if (k == sd) begin
          data = {$urandom, $urandom};
          data[7:0] = 8'hFB;
          ctrl = 8'h01;
        end
        if (k == td) begin
          if (k != sd) begin
            data = {$urandom, $urandom};
            ctrl = 8'h00;
          end
          data[8*lane +: 8] = 8'hFD;
          ctrl[lane] = 1'b1;
          for (int j = lane + 1; j < 8; j++) begin
            data[8*j +: 8] = 8'h07;
            ctrl[j] = 1'b1;
          end
        end
      end
      i_mii_data = data;
      i_mii_ctrl = ctrl;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_start, start_seen, have_end;
    int c0, last_end, gv;
    exp_t e;
    logic [NUM_REQ-1:0] vec;
    prev_start = 0; start_seen = 0; have_end = 0; c0 = 0; last_end = 0;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        prev_start = 0; start_seen = 0; have_end = 0;
      end else begin
        gv = batch_cyc;
        if (have_end && last_end + IFG > gv) gv = last_end + IFG;
        gv = gv + 2;
        if (have_end && cyc == last_end + IFG - 1) chk("busy_in_gap", o_busy, 1);
        if (have_end && cyc == last_end + IFG)     chk("busy_after_gap", o_busy, 0);
        if (o_start && !prev_start) begin
          c0 = cyc;
          start_seen = 1;
          if (exp_q.size() == 0) chk("start_unexpected", exp_q.size(), 1);
          else begin
            chk("start_latency", cyc, gv);
            chk("start_sel", o_sel, exp_q[0].idx);
          end
        end
        if (start_seen && exp_q.size() > 0 && exp_q[0].sd < TMO) begin
          if (cyc == c0 + exp_q[0].sd)     chk("start_held", o_start, 1);
          if (cyc == c0 + exp_q[0].sd + 1) chk("start_drop", o_start, 0);
        end
        if ((o_ack | o_err) != '0) begin
          if (exp_q.size() == 0) chk("unexpected_pulse", {o_ack, o_err}, 0);
          else begin
            e   = exp_q.pop_front();
            vec = NUM_REQ'(1) << e.idx;
            chk("ack_vec", o_ack, e.is_ack ? vec : '0);
            chk("err_vec", o_err, e.is_ack ? '0 : vec);
            chk("frame_count", o_frame_count, e.fc);
            chk("sel", o_sel, e.idx);
            chk("dest", o_dest_address, e.dest);
            chk("eth_type", o_eth_type, e.typ);
            chk("payload_len", o_payload_length, e.len);
            chk("src", o_src_address, e.src);
            chk("start_low_at_end", o_start, 0);
            chk("start_seen", start_seen, !e.badlen);
            if (e.badlen)      chk("err_latency", cyc, gv);
            else if (e.is_ack) chk("ack_latency", cyc, c0 + e.td + 1);
            else               chk("timeout_latency", cyc, c0 + TMO);
          end
          last_end   = cyc;
          have_end   = 1;
          start_seen = 0;
        end
      end
      prev_start = o_start;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0;
    i_req = '0;
    i_dest_address = '0;
    i_eth_type = '0;
    i_payload_length = '0;
    i_src_address = '0;
    for (int k = 0; k < NUM_REQ; k++) begin gen_sd[k] = 1; gen_td[k] = 2; end
    repeat (3) @(negedge clk);
    chk("rst_start", o_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ack_err", {o_ack, o_err}, 0);
    chk("rst_fcnt", o_frame_count, 0);
    chk("rst_sel", o_sel, 0);
    i_rst_n = 1'b1;

    // Single frame, broadcast destination.
    i_src_address = {$urandom, $urandom};
    set_desc(0, 48'hFFFFFFFFFFFF, 16'h0800, 16'd8, 1, 10);
    issue(4'b0001);
    wait_done(200);

    // Illegal lengths for requester 2, then a pair that exposes the pointer.
    set_desc(2, {$urandom, $urandom}, 16'(($urandom)), 16'd0, 1, 5);
    issue(4'b0100);
    wait_done(200);
    set_desc(2, {$urandom, $urandom}, 16'(($urandom)), 16'd65, 1, 5);
    issue(4'b0100);
    wait_done(200);
    set_desc(0, {$urandom, $urandom}, 16'h86DD, 16'd1, 2, 6);
    set_desc(3, {$urandom, $urandom}, 16'h0806, 16'd64, 1, 1);
    issue(4'b1001);
    wait_done(300);

    // Watchdog expiry, then terminate on the last legal cycle.
    set_desc(1, {$urandom, $urandom}, 16'h0800, 16'd40, 3, NEVER);
    issue(4'b0010);
    wait_done(1000);
    set_desc(2, {$urandom, $urandom}, 16'h0800, 16'd64, 4, TMO - 1);
    issue(4'b0100);
    wait_done(1000);

    // Reset in the middle of a frame.
    set_desc(1, {$urandom, $urandom}, 16'h0800, 16'd20, 2, NEVER);
    issue(4'b0010);
    for (int n = 0; n < 40 && !o_start; n++) @(negedge clk);
    chk("pre_reset_start", o_start, 1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_start", o_start, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_ack_err", {o_ack, o_err}, 0);
    chk("mid_rst_fcnt", o_frame_count, 0);
    chk("mid_rst_desc", {o_dest_address, o_eth_type}, 0);
    chk("mid_rst_len_sel", {o_payload_length, o_sel}, 0);
    chk("mid_rst_src", o_src_address, 0);
    exp_q.delete();
    m_ptr = 0;
    m_fc  = 16'd0;
    i_req = '0;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three requesters held together, served from requester 0.
    set_desc(0, {$urandom, $urandom}, 16'h0800, 16'd10, 1, 8);
    set_desc(1, {$urandom, $urandom}, 16'h0800, 16'd30, 2, 2);
    set_desc(3, {$urandom, $urandom}, 16'h0800, 16'd60, 3, 15);
    issue(4'b1011);
    wait_done(400);

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      logic [NUM_REQ-1:0] mask;
      mask = NUM_REQ'($urandom_range(1, 15));
      i_src_address = {$urandom, $urandom};
      for (int k = 0; k < NUM_REQ; k++) begin
        int sd;
        logic [15:0] len;
        sd  = int'($urandom_range(1, 6));
        len = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1) * $urandom_range(65, 70))
                                          : 16'($urandom_range(1, PMAX));
        set_desc(k, {$urandom, $urandom}, 16'($urandom), len, sd, sd + int'($urandom_range(0, 30)));
      end
      issue(mask);
      wait_done(2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/mac_tx_scheduler.md
Name: mac_tx_scheduler

Overview:
Shares the single MAC/MII frame generator (mac_mii_top) between NUM_REQ frame requesters.
- Picks a requester by round-robin and latches its descriptor (dest address, eth type, payload length).
- Drives the generator's start and header inputs, plus a payload-mux select, and watches the 64-bit MII output for start/terminate characters to detect frame end.
- Enforces an inter-frame gap and a watchdog timeout before serving the next requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PAYLOAD_MAX_SIZE, 64, largest legal payload length in bytes
IFG_CYCLES, 3, idle cycles after frame end before next grant (>=1)
TIMEOUT_CYCLES, 512, max cycles from start assertion to terminate detection
START_CODE, 8'hFB, MII start control character
TERM_CODE, 8'hFD, MII terminate control character

Ports:
clk  in  1  clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_req  in  NUM_REQ  level request; held until o_ack or o_err for that requester
i_dest_address  in  NUM_REQ*48  per-requester destination MAC (requester k at [48k+47:48k])
i_eth_type  in  NUM_REQ*16  per-requester eth type
i_payload_length  in  NUM_REQ*16  per-requester payload length
i_src_address  in  48  shared source MAC, passed through
i_mii_data  in  64  generator o_mii_data; lane k = bits [8k+7:8k]
i_mii_ctrl  in  8  generator o_mii_valid; bit k marks lane k as control
o_start  out  1  to generator i_start
o_dest_address  out  48  latched descriptor field
o_src_address  out  48  registered copy of i_src_address, latched in LOAD
o_eth_type  out  16  latched descriptor field
o_payload_length  out  16  latched descriptor field
o_sel  out  $clog2(NUM_REQ)  granted index for the external payload mux
o_busy  out  1  high in any state except IDLE
o_ack  out  NUM_REQ  one-cycle pulse, one-hot: frame completed
o_err  out  NUM_REQ  one-cycle pulse, one-hot: descriptor rejected or timeout
o_frame_count  out  16  completed frames; wraps 0xFFFF->0

Behaviour:
- All outputs registered. Async reset clears all outputs to 0, the round-robin pointer to 0, state to IDLE, and all counters. Reset mid-frame abandons the frame with no ack/err pulse.
- States: IDLE, LOAD, START, WAIT_TERM, GAP.
- IDLE:
  - If any i_req bit is set, the rr_arbiter grants the first set bit searching from ptr upward with wrap.
  - Latch the granted index; go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - Latch the granted descriptor and i_src_address into outputs; o_sel = granted index.
  - Payload length 0 or > PAYLOAD_MAX_SIZE: pulse o_err[g] next cycle, ptr = g+1 mod NUM_REQ, go to GAP.
  - Otherwise go to START.
- Latency: request seen in IDLE at cycle t gives o_start=1 at t+2.
- START:
  - o_start held high; timeout counter runs.
  - Start detect (i_mii_ctrl[0]=1 and i_mii_data[7:0]==START_CODE): o_start=0 the next cycle, go to WAIT_TERM.
- WAIT_TERM:
  - Terminate detect = any lane k with i_mii_ctrl[k]=1 and lane data == TERM_CODE.
  - On detect: pulse o_ack[g], increment o_frame_count, ptr = g+1 mod NUM_REQ, go to GAP.
- Start and terminate in the same cycle while in START: o_start drops and the frame completes as in WAIT_TERM.
- Timeout counter:
  - Cleared on entering START; counts every cycle in START and WAIT_TERM.
  - When it reaches TIMEOUT_CYCLES: o_start=0, pulse o_err[g], ptr advances, go to GAP.
  - If timeout and terminate fall in the same cycle, terminate wins.
- GAP:
  - Count IFG_CYCLES cycles, then go to IDLE.
  - i_req is ignored during GAP, so a requester dropping req after its ack is never re-granted.
- Descriptor outputs and o_sel hold their values until the next LOAD.
- Changes to i_req or descriptor inputs after LOAD do not affect the frame in flight.
- A requester that drops i_req before its grant simply loses arbitration; this is not an error.

Decomposition:
- Package mac_tx_sched_pkg holds:
  - state enum (IDLE, LOAD, START, WAIT_TERM, GAP);
  - START_CODE/TERM_CODE defaults;
  - MAC_ADDR_W=48, ETH_TYPE_W=16, LEN_W=16.
- One sub-module: rr_arbiter (combinational grant from req vector and pointer, outputting index and valid). The FSM owns the pointer register.

Test Plan:
1. Reset, then i_req=4'b0001, len=8, dest=FFFFFFFFFFFF, type=0800, with a generator model returning START_CODE at o_start+1 and TERM at +10:
   - o_start high 2 cycles after req, low 1 cycle after start detect;
   - o_ack=0001 one cycle after TERM; o_frame_count=1; o_busy low after 3 GAP cycles.
2. i_req=4'b1011 held; each requester drops req on its ack:
   - grant order 0,1,3; o_sel 0,1,3; acks in that order; o_frame_count=3.
3. Requester 2 with len=0, then len=65:
   - o_err=0100 each time, o_start never asserted, ptr advances to 3.
4. Model never emits TERM, TIMEOUT_CYCLES=512:
   - o_err pulse exactly 512 cycles after entering START; o_start low; no ack.
5. Assert i_rst_n=0 mid WAIT_TERM:
   - all outputs 0 immediately; no ack/err; after release, re-grant starts from requester 0.
6. TERM and timeout in the same cycle:
   - o_ack pulses, o_err stays 0.
